// File: rtl/bit_pattern_serializer_if.sv
// Load handshake and serial output bundle for bit_pattern_serializer.
// master drives patterns and control; slave (the serializer) drives the bit stream.
interface bit_pattern_serializer_if #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1),
  parameter int IW    = $clog2(WIDTH)
);
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    load_len;
  logic             load_valid;
  logic             load_ready;
  logic             loop;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic [IW-1:0]    bit_index;

  modport master (
    output load_data, load_len, load_valid, loop, abort,
    input  load_ready, x, x_valid, busy, bit_index
  );

  modport slave (
    input  load_data, load_len, load_valid, loop, abort,
    output load_ready, x, x_valid, busy, bit_index
  );
endinterface

// File: rtl/bit_pattern_serializer.sv
// Parallel-to-serial pattern source, MSB first, DIV clocks per bit; first x_valid 1 cycle after accept.
// load_ready only in IDLE, loads offered while busy are ignored (never stalls); abort ends a burst next edge.
module bit_pattern_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int LW    = $clog2(WIDTH + 1),
  parameter int IW    = $clog2(WIDTH)
) (
  input logic                     clk,
  input logic                     reset,
  bit_pattern_serializer_if.slave bus
);
  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [LW-1:0]   WIDTH_L  = LW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [IW-1:0]    last_q, last_n;
  logic [IW-1:0]    bcnt_q, bcnt_n;
  logic [DW-1:0]    dcnt_q, dcnt_n;
  logic [LW-1:0]    eff_len;
  logic [IW-1:0]    eff_last;

  // Zero or oversize lengths fall back to the full pattern width.
  always_comb begin
    eff_len  = ((bus.load_len == '0) || (bus.load_len > WIDTH_L)) ? WIDTH_L : bus.load_len;
    eff_last = IW'(eff_len - LW'(1));
  end

  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    last_n  = last_q;
    bcnt_n  = bcnt_q;
    dcnt_n  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid && bus.load_ready) begin
          state_n = SHIFT;
          pat_n   = bus.load_data;
          last_n  = eff_last;
          bcnt_n  = eff_last;
          dcnt_n  = '0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (dcnt_q != DIV_LAST) begin
          dcnt_n = dcnt_q + DW'(1);
        end else begin
          dcnt_n = '0;
          if (bcnt_q != '0) begin
            bcnt_n = bcnt_q - IW'(1);
          end else if (bus.loop) begin
            bcnt_n = last_q;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pat_q          <= '0;
      last_q         <= '0;
      bcnt_q         <= '0;
      dcnt_q         <= '0;
      bus.load_ready <= 1'b1;
      bus.x          <= 1'b0;
      bus.x_valid    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.bit_index  <= '0;
    end else begin
      state_q        <= state_n;
      pat_q          <= pat_n;
      last_q         <= last_n;
      bcnt_q         <= bcnt_n;
      dcnt_q         <= dcnt_n;
      bus.load_ready <= (state_n == IDLE);
      bus.busy       <= (state_n == SHIFT);
      bus.x          <= (state_n == SHIFT) && pat_n[bcnt_n];
      bus.x_valid    <= (state_n == SHIFT) && (dcnt_n == '0);
      bus.bit_index  <= (state_n == SHIFT) ? bcnt_n : '0;
    end
  end
endmodule

// File: tb/tb_bit_pattern_serializer.sv
// Directed bench: instance a uses DIV=4, instance b uses DIV=1; both WIDTH=8.
module tb_bit_pattern_serializer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bit_pattern_serializer_if #(.WIDTH(8)) a_if ();
  bit_pattern_serializer_if #(.WIDTH(8)) b_if ();

  bit_pattern_serializer #(.WIDTH(8), .DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  bit_pattern_serializer #(.WIDTH(8), .DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  // 8'b1011_0010 sent MSB first
  int seq_b2 [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_b2(input string tag, input logic [3:0] len);
    @(negedge clk);
    a_if.load_data  = 8'hB2;
    a_if.load_len   = len;
    a_if.load_valid = 1'b1;
    @(negedge clk);
    a_if.load_valid = 1'b0;
    chk({tag, "_ready_lo"}, a_if.load_ready, 0);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_x"}, a_if.x, seq_b2[i/4]);
      chk({tag, "_xv"}, a_if.x_valid, (i % 4 == 0));
      chk({tag, "_busy"}, a_if.busy, 1);
      if (i % 4 == 0) chk({tag, "_idx"}, a_if.bit_index, 7 - i/4);
    end
    @(negedge clk);
    chk({tag, "_end_ready"}, a_if.load_ready, 1);
    chk({tag, "_end_busy"}, a_if.busy, 0);
    chk({tag, "_end_x"}, a_if.x, 0);
    chk({tag, "_end_xv"}, a_if.x_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    a_if.load_data = '0; a_if.load_len = '0; a_if.load_valid = 1'b0; a_if.loop = 1'b0; a_if.abort = 1'b0;
    b_if.load_data = '0; b_if.load_len = '0; b_if.load_valid = 1'b0; b_if.loop = 1'b0; b_if.abort = 1'b0;
    #12;
    chk("rst_ready", a_if.load_ready, 1);
    chk("rst_x", a_if.x, 0);
    chk("rst_xv", a_if.x_valid, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_idx", a_if.bit_index, 0);
    chk("rst_b_ready", b_if.load_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // abort while idle is ignored
    a_if.abort = 1'b1;
    @(negedge clk);
    a_if.abort = 1'b0;
    chk("idle_abort_ready", a_if.load_ready, 1);
    chk("idle_abort_busy", a_if.busy, 0);

    run_b2("len8", 4'd8);
    run_b2("len0", 4'd0);
    run_b2("len15", 4'd15);

    // DIV=1: 8'hFF len 3, load_valid held high so the idle-cycle reload is taken
    @(negedge clk);
    b_if.load_data = 8'hFF; b_if.load_len = 4'd3; b_if.load_valid = 1'b1;
    @(negedge clk);
    b_if.load_data = 8'h00; b_if.load_len = 4'd5;
    chk("d1_c1_x", b_if.x, 1); chk("d1_c1_xv", b_if.x_valid, 1); chk("d1_c1_idx", b_if.bit_index, 2);
    chk("d1_c1_ready", b_if.load_ready, 0);
    @(negedge clk);
    chk("d1_c2_x", b_if.x, 1); chk("d1_c2_xv", b_if.x_valid, 1); chk("d1_c2_idx", b_if.bit_index, 1);
    @(negedge clk);
    chk("d1_c3_x", b_if.x, 1); chk("d1_c3_xv", b_if.x_valid, 1); chk("d1_c3_idx", b_if.bit_index, 0);
    @(negedge clk);
    chk("d1_gap_ready", b_if.load_ready, 1); chk("d1_gap_x", b_if.x, 0);
    chk("d1_gap_xv", b_if.x_valid, 0); chk("d1_gap_busy", b_if.busy, 0);
    b_if.load_data = 8'h05; b_if.load_len = 4'd3;
    @(negedge clk);
    b_if.load_valid = 1'b0;
    chk("d1_r1_x", b_if.x, 1); chk("d1_r1_xv", b_if.x_valid, 1); chk("d1_r1_busy", b_if.busy, 1);
    @(negedge clk);
    chk("d1_r2_x", b_if.x, 0); chk("d1_r2_xv", b_if.x_valid, 1);
    @(negedge clk);
    chk("d1_r3_x", b_if.x, 1); chk("d1_r3_xv", b_if.x_valid, 1);
    @(negedge clk);
    chk("d1_r_end_ready", b_if.load_ready, 1); chk("d1_r_end_x", b_if.x, 0);

    // loop: 2-bit pattern 10 (upper bits ignored), loop dropped during pass two
    @(negedge clk);
    a_if.load_data = 8'hF2; a_if.load_len = 4'd2; a_if.loop = 1'b1; a_if.load_valid = 1'b1;
    @(negedge clk);
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("loop_x", a_if.x, ((i / 4) % 2 == 0));
      chk("loop_xv", a_if.x_valid, (i % 4 == 0));
      chk("loop_busy", a_if.busy, 1);
      if (i == 9) a_if.loop = 1'b0;
    end
    @(negedge clk);
    chk("loop_end_ready", a_if.load_ready, 1);
    chk("loop_end_busy", a_if.busy, 0);
    chk("loop_end_x", a_if.x, 0);

    // abort on cycle 6 of a burst
    @(negedge clk);
    a_if.load_data = 8'hB2; a_if.load_len = 4'd8; a_if.load_valid = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      a_if.load_valid = 1'b0;
      if (j == 5) chk("abort_c5_xv", a_if.x_valid, 1);
    end
    chk("abort_c6_busy", a_if.busy, 1);
    chk("abort_c6_idx", a_if.bit_index, 6);
    a_if.abort = 1'b1;
    @(negedge clk);
    a_if.abort = 1'b0;
    chk("abort_c7_busy", a_if.busy, 0);
    chk("abort_c7_ready", a_if.load_ready, 1);
    chk("abort_c7_x", a_if.x, 0);
    chk("abort_c7_xv", a_if.x_valid, 0);

    // load and abort together in IDLE: load wins
    a_if.load_data = 8'h80; a_if.load_len = 4'd8; a_if.load_valid = 1'b1; a_if.abort = 1'b1;
    @(negedge clk);
    a_if.load_valid = 1'b0; a_if.abort = 1'b0;
    chk("ldab_busy", a_if.busy, 1);
    chk("ldab_x", a_if.x, 1);
    chk("ldab_xv", a_if.x_valid, 1);
    chk("ldab_idx", a_if.bit_index, 7);
    a_if.abort = 1'b1;
    @(negedge clk);
    a_if.abort = 1'b0;
    chk("ldab_end_busy", a_if.busy, 0);

    // asynchronous reset mid-burst, then a fresh load
    a_if.load_data = 8'hFF; a_if.load_len = 4'd8; a_if.load_valid = 1'b1;
    @(negedge clk);
    a_if.load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_busy", a_if.busy, 1);
    chk("arst_pre_x", a_if.x, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", a_if.busy, 0);
    chk("arst_x", a_if.x, 0);
    chk("arst_ready", a_if.load_ready, 1);
    chk("arst_idx", a_if.bit_index, 0);
    @(negedge clk);
    reset = 1'b0;
    a_if.load_data = 8'hB2; a_if.load_len = 4'd8; a_if.load_valid = 1'b1;
    @(negedge clk);
    a_if.load_valid = 1'b0;
    chk("post_rst_x", a_if.x, 1);
    chk("post_rst_xv", a_if.x_valid, 1);
    chk("post_rst_busy", a_if.busy, 1);
    @(negedge clk);
    chk("post_rst_c2_xv", a_if.x_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
